cv32e40x_div_seq: RTL

//  Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one bit per cycle with early start.

---
 rtl/cv32e40x_div_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40x_div_seq.sv
// ---------------------------------------------------------------------------
// cv32e40x_div_seq
//   Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   Produces one quotient bit per cycle. The ALU's CLZ unit is borrowed to
//   normalise the divisor, and its shifter aligns the divisor. The loop then
//   runs clz(|b|)+1 times. A sign correction is applied on the way into
//   DONE, and the result is held there until the consumer takes it.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   opcode_i[1:0]          bit0 = unsigned, bit1 = remainder
//   op_a_i, op_b_i         dividend, divisor
//   valid_i / ready_o      request handshake (ready_o only in IDLE)
//   kill_i                 abort; wins over accept and ready_i
//   result_o / valid_o     result handshake, consumer acknowledges with ready_i
//   alu_clz_*              borrowed CLZ: bit-reversed |b| out, count back in
//   alu_shift_*            borrowed shifter: amount out, |b| << amt back in
//
// Handshake: a request transfers on a rising edge where valid_i && ready_o
// && !kill_i. A result transfers on a rising edge where valid_o && ready_i
// && !kill_i. Outputs do not depend combinationally on valid_i or ready_i.
// ---------------------------------------------------------------------------
module cv32e40x_div_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  opcode_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        kill_i,
   output logic [31:0] result_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        alu_clz_en_o,
   output logic [31:0] alu_clz_data_rev_o,
   input  logic [5:0]  alu_clz_result_i,
   output logic        alu_shift_en_o,
   output logic [5:0]  alu_shift_amt_o,
   input  logic [31:0] alu_op_b_shifted_i
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLZ   = 3'd1,
      S_SHIFT = 3'd2,
      S_ITER  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic        neg_a_q, neg_a_d;
   logic        neg_b_q, neg_b_d;
   logic        rem_sel_q, rem_sel_d;
   logic [31:0] abs_a_q, abs_a_d;
   logic [31:0] abs_b_q, abs_b_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] result_q, result_d;

   // Operand decode at accept time
   logic        in_signed;
   logic        in_neg_a, in_neg_b;
   logic [31:0] in_abs_a, in_abs_b;

   always_comb begin
      in_signed = ~opcode_i[0];
      in_neg_a  = in_signed & op_a_i[31];
      in_neg_b  = in_signed & op_b_i[31];
      // -0x80000000 wraps back to 0x80000000, which is the correct magnitude
      // when read as unsigned.
      in_abs_a  = in_neg_a ? (32'd0 - op_a_i) : op_a_i;
      in_abs_b  = in_neg_b ? (32'd0 - op_b_i) : op_b_i;
   end

   // One restoring step, plus the sign-corrected results it would give
   logic        step_ge;
   logic [31:0] step_rem, step_quo;
   logic [31:0] fix_rem, fix_quo;
   logic [31:0] zero_rem;

   always_comb begin
      step_ge  = (rem_q >= dvs_q);
      step_rem = step_ge ? (rem_q - dvs_q) : rem_q;
      step_quo = {quo_q[30:0], step_ge};
      fix_quo  = (neg_a_q ^ neg_b_q) ? (32'd0 - step_quo) : step_quo;
      fix_rem  = neg_a_q ? (32'd0 - step_rem) : step_rem;
      // Divide by zero: re-applying the dividend's sign restores the original op_a.
      zero_rem = neg_a_q ? (32'd0 - abs_a_q) : abs_a_q;
   end

   // Bit-reversed |b| for the ALU's CLZ unit
   logic [31:0] abs_b_rev;

   always_comb begin
      abs_b_rev = '0;
      for (int i = 0; i < 32; i++) begin
         abs_b_rev[i] = abs_b_q[31-i];
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      rem_sel_d = rem_sel_q;
      abs_a_d   = abs_a_q;
      abs_b_d   = abs_b_q;
      cnt_d     = cnt_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      result_d  = result_q;

      unique case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               neg_a_d   = in_neg_a;
               neg_b_d   = in_neg_b;
               rem_sel_d = opcode_i[1];
               abs_a_d   = in_abs_a;
               abs_b_d   = in_abs_b;
               state_d   = S_CLZ;
            end
         end
         S_CLZ: begin
            cnt_d = alu_clz_result_i;
            if (abs_b_q == 32'd0) begin
               result_d = rem_sel_q ? zero_rem : 32'hFFFF_FFFF;
               state_d  = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            dvs_d   = alu_op_b_shifted_i;
            rem_d   = abs_a_q;
            quo_d   = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            dvs_d = {1'b0, dvs_q[31:1]};
            cnt_d = cnt_q - 6'd1;
            // The last step's result goes straight into result_q, so the
            // value is ready on the same edge that enters DONE.
            if (cnt_q == 6'd0) begin
               result_d = rem_sel_q ? fix_rem : fix_quo;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // kill_i overrides every transition, including accept and result take.
      if (kill_i) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         rem_sel_q <= 1'b0;
         abs_a_q   <= '0;
         abs_b_q   <= '0;
         cnt_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         rem_sel_q <= rem_sel_d;
         abs_a_q   <= abs_a_d;
         abs_b_q   <= abs_b_d;
         cnt_q     <= cnt_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         result_q  <= result_d;
      end
   end

   // Outputs
   always_comb begin
      ready_o            = (state_q == S_IDLE);
      valid_o            = (state_q == S_DONE);
      result_o           = result_q;
      alu_clz_en_o       = (state_q == S_CLZ);
      alu_clz_data_rev_o = (state_q == S_CLZ) ? abs_b_rev : 32'd0;
      alu_shift_en_o     = (state_q == S_SHIFT);
      alu_shift_amt_o    = (state_q == S_SHIFT) ? cnt_q : 6'd0;
   end

endmodule
